// File: rtl/a0_seg_display_pkg.sv
// Shared seven-segment display constants: active-low hex font and blank pattern.
// Segment bit order is {g,f,e,d,c,b,a}.
package a0_seg_display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/a0_seg_display_hex_to_7seg.sv
// Combinational nibble to active-low seven-segment lookup.
module hex_to_7seg
  import a0_seg_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  assign seg_c = HEX_FONT[nib];

endmodule

// File: rtl/a0_seg_display.sv
// Multiplexed hex display of the core's a0 register with per-frame snapshot,
// anti-ghosting dark cycles and optional leading-zero suppression.
module a0_seg_display
  import a0_seg_display_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GHOST_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a0,
  input  logic                  hold,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SNAP_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SNAP_W-1:0]     snap_q, snap_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic [SNAP_W-1:0] a0_ext_c;
  logic [SNAP_W-1:0] upper_c;
  logic [3:0]        nib_c;
  logic [6:0]        font_c;
  logic              tick_c;
  logic              frame_end_c;
  logic              blank_c;

  // Fit a0 to the digit array: zero-extend narrow data, drop excess high bits.
  if (DATA_WIDTH >= SNAP_W) begin : g_trunc
    assign a0_ext_c = a0[SNAP_W-1:0];
  end else begin : g_zext
    assign a0_ext_c = {{(SNAP_W-DATA_WIDTH){1'b0}}, a0};
  end

  hex_to_7seg u_font (
    .nib   (nib_c),
    .seg_c (font_c)
  );

  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    snap_d      = snap_q;
    an_d        = '1;
    seg_d       = SEG_OFF;
    tick_c      = (cnt_q == CNT_W'(SCAN_DIV - 1));
    frame_end_c = tick_c && (idx_q == IDX_W'(NUM_DIGITS - 1));

    // Digit under scan plus everything above it; zero means a leading zero.
    upper_c = snap_q >> {idx_q, 2'b00};
    nib_c   = upper_c[3:0];
    blank_c = blank_lz && (idx_q != '0) && (upper_c == '0);

    if (tick_c) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (frame_end_c && !hold) begin
      snap_d = a0_ext_c;
    end

    if (!((cnt_q < CNT_W'(GHOST_CYCLES)) || blank_c)) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = font_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      an_q   <= '1;
      seg_q  <= SEG_OFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_a0_seg_display.sv
// Self-checking bench for a0_seg_display: cycle scoreboard plus directed checks
// on a 32-bit instance and a 16-bit (zero-extended) instance.
module tb_a0_seg_display;

  localparam int SD = 4;
  localparam int GC = 1;
  localparam int ND = 8;

  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic [7:0] an_n;
    logic [6:0] seg_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        blank_lz;
  logic [31:0] a0;
  logic [15:0] a0n;
  logic [6:0]  seg, seg_n;
  logic        dp, dp_n;
  logic [7:0]  an, an_n;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          p      = 0;
  logic [31:0] m_snap, m_snap_n;
  exp_t        sbq[$];

  always #5 clk = ~clk;

  a0_seg_display #(
    .DATA_WIDTH(32), .NUM_DIGITS(ND), .SCAN_DIV(SD), .GHOST_CYCLES(GC)
  ) dut (
    .clk(clk), .rst(rst), .a0(a0), .hold(hold), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .an(an)
  );

  a0_seg_display #(
    .DATA_WIDTH(16), .NUM_DIGITS(ND), .SCAN_DIV(SD), .GHOST_CYCLES(GC)
  ) dut_n (
    .clk(clk), .rst(rst), .a0(a0n), .hold(hold), .blank_lz(blank_lz),
    .seg(seg_n), .dp(dp_n), .an(an_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected display for cycle pp since reset, from the spec's scan rules.
  function automatic void model_out(input logic [31:0] s, input int pp, input logic blz,
                                    output logic [7:0] ea, output logic [6:0] es);
    int          c;
    int          d;
    logic [31:0] up;
    logic        blank;
    c     = pp % SD;
    d     = (pp / SD) % ND;
    up    = s >> (4 * d);
    blank = blz && (d != 0) && (up == 32'h0);
    if (c < GC || blank) begin
      ea = 8'hFF;
      es = 7'h7F;
    end else begin
      ea = ~(8'h01 << d);
      es = FONT[up[3:0]];
    end
  endfunction

  // One clock: predict, advance the model, then compare after the edge.
  task automatic step();
    exp_t e;
    model_out(m_snap, p, blank_lz, e.an, e.seg);
    model_out(m_snap_n, p, blank_lz, e.an_n, e.seg_n);
    sbq.push_back(e);
    if ((p % SD == SD - 1) && ((p / SD) % ND == ND - 1) && !hold) begin
      m_snap   = a0;
      m_snap_n = {16'h0, a0n};
    end
    p++;
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_an", 32'(an), 32'(e.an));
    chk("sb_seg", 32'(seg), 32'(e.seg));
    chk("sb_an_n", 32'(an_n), 32'(e.an_n));
    chk("sb_seg_n", 32'(seg_n), 32'(e.seg_n));
    chk("sb_dp", 32'(dp), 32'h1);
    chk("sb_dp_n", 32'(dp_n), 32'h1);
  endtask

  task automatic run_to(input int target);
    while (p < target) step();
  endtask

  task automatic model_reset();
    p        = 0;
    m_snap   = 32'h0;
    m_snap_n = 32'h0;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ea, input logic [6:0] es);
    chk({tag, "_an"}, 32'(an), 32'(ea));
    chk({tag, "_seg"}, 32'(seg), 32'(es));
  endtask

  task automatic chk_out_n(input string tag, input logic [7:0] ea, input logic [6:0] es);
    chk({tag, "_an_n"}, 32'(an_n), 32'(ea));
    chk({tag, "_seg_n"}, 32'(seg_n), 32'(es));
  endtask

  initial begin
    rst      = 1'b1;
    hold     = 1'b0;
    blank_lz = 1'b0;
    a0       = 32'h0;
    a0n      = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst", 8'hFF, 7'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    rst = 1'b0;
    a0  = 32'h1234_5678;
    a0n = 16'hBEEF;

    // First slot after release: one dark cycle, then snapshot 0 on digit 0.
    run_to(1);   chk_out("first_dark", 8'hFF, 7'h7F);
    run_to(2);   chk_out("first_lit", 8'hFE, 7'h40);

    // Basic scan, frame 1.
    run_to(33);  chk_out("f1_d0_dark", 8'hFF, 7'h7F);
    run_to(34);  chk_out("f1_d0", 8'hFE, 7'h00);
    run_to(36);  chk_out("f1_d0_last", 8'hFE, 7'h00);
    run_to(46);  chk_out_n("nar_d3", 8'hF7, 7'h03);
    run_to(50);  chk_out_n("nar_d4", 8'hEF, 7'h40);
    run_to(62);  chk_out("f1_d7", 8'h7F, 7'h79);

    // Coherency: change a0 during digit 3 of frame 2.
    run_to(78);  a0 = 32'hFFFF_FFFF;
    run_to(82);  chk_out("coh_d4", 8'hEF, 7'h19);
    run_to(94);  chk_out("coh_d7", 8'h7F, 7'h79);
    run_to(98);  chk_out("coh_next_d0", 8'hFE, 7'h0E);

    // Leading-zero suppression.
    a0 = 32'h0000_00A5;
    blank_lz = 1'b1;
    run_to(126); chk_out("coh_next_d7", 8'h7F, 7'h0E);
    run_to(130); chk_out("lz_d0", 8'hFE, 7'h12);
    run_to(134); chk_out("lz_d1", 8'hFD, 7'h08);
    run_to(138); chk_out("lz_d2", 8'hFF, 7'h7F);
    a0 = 32'h0;
    run_to(142); chk_out_n("nar_lz_d3", 8'hF7, 7'h03);
    run_to(150); chk_out_n("nar_lz_d5", 8'hFF, 7'h7F);
    run_to(159); chk_out("lz_d7", 8'hFF, 7'h7F);
    run_to(162); chk_out("zero_d0", 8'hFE, 7'h40);
    run_to(166); chk_out("zero_d1", 8'hFF, 7'h7F);

    // Hold freezes the snapshot for several frames.
    a0 = 32'hDEAD_BEEF;
    blank_lz = 1'b0;
    run_to(194); chk_out("hold_d0", 8'hFE, 7'h0E);
    hold = 1'b1;
    a0   = 32'h0;
    run_to(258); chk_out("hold_f8_d0", 8'hFE, 7'h0E);
    run_to(318); chk_out("hold_f9_d7", 8'h7F, 7'h21);
    hold = 1'b0;
    run_to(322); chk_out("unhold_d0", 8'hFE, 7'h40);
    run_to(350); chk_out("unhold_d7", 8'h7F, 7'h40);

    // Hold rising on the frame-end edge blocks the load.
    run_to(351);
    hold = 1'b1;
    a0   = 32'h0000_0005;
    run_to(354); chk_out("hold_edge_d0", 8'hFE, 7'h40);
    hold = 1'b0;

    // Asynchronous reset mid-slot discards the snapshot and scan position.
    run_to(357);
    #2 rst = 1'b1;
    #1;
    chk_out("mid_rst", 8'hFF, 7'h7F);
    chk_out_n("mid_rst", 8'hFF, 7'h7F);
    chk("mid_rst_dp", 32'(dp), 32'h1);
    @(posedge clk);
    #1;
    chk_out("mid_rst_held", 8'hFF, 7'h7F);
    rst = 1'b0;
    model_reset();
    run_to(1);   chk_out("rerst_dark", 8'hFF, 7'h7F);
    run_to(2);   chk_out("rerst_d0", 8'hFE, 7'h40);
    run_to(40);  chk_out("rerst_f1_d1", 8'hFD, 7'h40);
    run_to(34 + 4 * SD);
    chk("sb_empty", 32'(sbq.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
